// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// Optional grant watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  req_tx_start,
  input  logic [31:0] req_tx_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [3:0]  grant,
  output logic [3:0]  req_tx_busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_DRAIN
  } state_t;

  state_t     state;
  logic [3:0] grant_q;
  logic [1:0] gidx;
  logic [1:0] ptr;
  logic [3:0] elig;
  logic [1:0] sel;
  logic [1:0] idx;
  logic       hit;
  logic       fwd;
  logic [7:0] gbyte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [3:0]    mask;
  logic          to_q;

  assign elig    = req & ~mask;
  assign timeout = to_q;
`else
  assign elig    = req;
  assign timeout = 1'b0;
`endif

  assign gbyte = req_tx_data[{gidx, 3'b000} +: 8];
  assign fwd   = (state == S_GRANT) & req_tx_start[gidx];

  assign tx_start    = fwd & ~rst;
  assign tx_data     = (state == S_GRANT && !rst) ? gbyte : 8'h00;
  assign grant       = grant_q;
  assign req_tx_busy = rst ? 4'hF : (~grant_q | {4{tx_busy}});

  // Search starts one past the last granted requester.
  always_comb begin
    sel = 2'd0;
    hit = 1'b0;
    idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!hit && elig[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_q <= 4'b0000;
      gidx    <= 2'd0;
      ptr     <= 2'd3;
`ifdef UART_ARB_TIMEOUT_EN
      cnt     <= '0;
      mask    <= 4'b0000;
      to_q    <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      to_q <= 1'b0;
      mask <= mask & req;
`endif
      case (state)
        S_IDLE: begin
          if (hit) begin
            grant_q <= 4'b0001 << sel;
            gidx    <= sel;
            ptr     <= sel;
            state   <= S_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!req[gidx]) begin
            grant_q <= 4'b0000;
            state   <= S_DRAIN;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (fwd || tx_busy) begin
            cnt <= '0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            grant_q <= 4'b0000;
            state   <= S_DRAIN;
            to_q    <= 1'b1;
            mask    <= (mask & req) | (4'b0001 << gidx);
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (!tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// Watchdog steps run only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_tx_start;
  logic [31:0] req_tx_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic [3:0]  req_tx_busy;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_tx_start (req_tx_start),
    .req_tx_data  (req_tx_data),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .grant        (grant),
    .req_tx_busy  (req_tx_busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_order [4];

  initial begin
    exp_order[0] = 4'b0010;
    exp_order[1] = 4'b0100;
    exp_order[2] = 4'b1000;
    exp_order[3] = 4'b0001;

    rst = 1'b1;
    req = 4'b0000;
    req_tx_start = 4'b0000;
    req_tx_data = 32'h0;
    tx_busy = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", req_tx_busy, 4'b1111);
    chk("rst_start", tx_start, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_data", tx_data, 8'h00);

    // Simultaneous requests 0 and 2
    rst = 1'b0;
    req = 4'b0101;
    tick();
    chk("rr_first", grant, 4'b0001);
    chk("rr_busy_view", req_tx_busy, 4'b1110);
    req = 4'b0100;
    tick();
    chk("rr_drain", grant, 4'b0000);
    tick();
    chk("rr_idle", grant, 4'b0000);
    tick();
    chk("rr_second", grant, 4'b0100);

    req = 4'b0000;
    tick();
    tick();
    chk("rel2", grant, 4'b0000);

    // Requester 1 sends "42\n", requester 2 injects a stray pulse
    req = 4'b0010;
    req_tx_data = 32'hEE_DD_00_CC;
    tick();
    chk("msg_grant", grant, 4'b0010);
    req_tx_data = 32'hEE_DD_34_CC;
    req_tx_start = 4'b0010;
    #1;
    chk("msg_b0_start", tx_start, 1'b1);
    chk("msg_b0_data", tx_data, 8'h34);
    tick();
    req_tx_start = 4'b0000;
    tx_busy = 1'b1;
    #1;
    chk("msg_gap_start", tx_start, 1'b0);
    chk("msg_busy_view", req_tx_busy, 4'b1111);
    tick();
    tx_busy = 1'b0;
    req_tx_data = 32'hEE_DD_32_CC;
    req_tx_start = 4'b0010;
    #1;
    chk("msg_b1_start", tx_start, 1'b1);
    chk("msg_b1_data", tx_data, 8'h32);
    tick();
    req_tx_start = 4'b0100;
    req_tx_data = 32'hEE_FF_32_CC;
    #1;
    chk("stray_start", tx_start, 1'b0);
    chk("stray_data", tx_data, 8'h32);
    tick();
    // Last byte with req dropping in the same cycle
    req_tx_start = 4'b0010;
    req_tx_data = 32'hEE_DD_0A_CC;
    req = 4'b0000;
    #1;
    chk("last_start", tx_start, 1'b1);
    chk("last_data", tx_data, 8'h0A);
    tick();
    req_tx_start = 4'b0000;
    tx_busy = 1'b1;
    chk("last_drain", grant, 4'b0000);
    req = 4'b0001;
    req_tx_start = 4'b0001;
    #1;
    chk("drain_start", tx_start, 1'b0);
    chk("drain_data", tx_data, 8'h00);
    tick();
    req_tx_start = 4'b0000;
    chk("drain_hold1", grant, 4'b0000);
    tick();
    chk("drain_hold2", grant, 4'b0000);
    tx_busy = 1'b0;
    tick();
    chk("drain_exit", grant, 4'b0000);
    tick();
    chk("pending_grant", grant, 4'b0001);

    // All four requesting with one-cycle release
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req = 4'b1111 & ~grant;
      tick();
      chk("rr4_drop", grant, 4'b0000);
      req = 4'b1111;
      tick();
      tick();
      chk("rr4_order", grant, exp_order[i]);
    end

    // Reset while requester 1 holds the grant
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0010;
    tick();
    chk("pre_rst_grant", grant, 4'b0010);
    tx_busy = 1'b1;
    req_tx_start = 4'b0010;
    rst = 1'b1;
    #1;
    chk("in_rst_start", tx_start, 1'b0);
    chk("in_rst_busy", req_tx_busy, 4'b1111);
    tick();
    chk("post_rst_grant", grant, 4'b0000);
    chk("post_rst_start", tx_start, 1'b0);
    rst = 1'b0;
    req_tx_start = 4'b0000;
    tx_busy = 1'b0;
    req = 4'b0011;
    tick();
    chk("after_rst_first", grant, 4'b0001);
    chk("no_timeout", timeout, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd_hold", grant, 4'b0001);
    end
    tick();
    chk("wd_revoke", grant, 4'b0000);
    chk("wd_pulse", timeout, 1'b1);
    tick();
    chk("wd_pulse_end", timeout, 1'b0);
    tick();
    chk("wd_next", grant, 4'b0010);
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    chk("wd_masked", grant, 4'b0000);
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    chk("wd_unmasked", grant, 4'b0001);
`else
    repeat (20) tick();
    chk("no_wd_hold", grant, 4'b0001);
    chk("no_wd_timeout", timeout, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
